gain_scale_sat: RTL and testbench
=================================

GAIN_SCALE_SAT -- requirements
Module: gain_scale_sat

Interface
REQ-001 SHALL have parameter A_W, default 16: width of the signed input sample.
REQ-002 SHALL have parameter G_W, default 16: width of the unsigned gain.
REQ-003 SHALL have parameter SHIFT, default 8: arithmetic right-shift applied to the product (fixed-point gain format).
REQ-004 SHALL have parameter OUT_W, default 16: width of the signed saturated output.
REQ-005 SHALL have port clk  input  1: single clock, all logic on rising edge.
REQ-006 SHALL have port rst_n  input  1: reset, asynchronous, active-low.
REQ-007 SHALL have port in_valid  input  1: in_a/in_g valid this cycle.
REQ-008 SHALL have port in_ready  output  1: block accepts input this cycle.
REQ-009 SHALL have port in_a  input  A_W: signed sample (two's complement).
REQ-010 SHALL have port in_g  input  G_W: unsigned gain.
REQ-011 SHALL have port out_valid  output  1: out_y valid.
REQ-012 SHALL have port out_ready  input  1: downstream accepts out_y.
REQ-013 SHALL have port out_y  output  OUT_W: signed scaled, saturated result.
REQ-014 SHALL have port out_sat  output  1: out_y was clamped, qualified by out_valid.

Function
REQ-015 SHALL transfer an input when in_valid && in_ready, and an output when out_valid && out_ready.
REQ-016 SHALL form stage-1 product as signed(in_a) times signed({1'b0,in_g}), width A_W+G_W+1, so that in_g is never sign-interpreted and in_a is never zero-extended.
REQ-017 SHALL register the product and a stage-1 valid flag in stage 1.
REQ-018 SHALL compute in stage 2: optional rounding (REQ-031), arithmetic right shift by SHIFT, then clamp to [-2^(OUT_W-1), 2^(OUT_W-1)-1], registering out_y, out_sat, out_valid.
REQ-019 SHALL set out_sat=1 iff the shifted value lies outside the OUT_W signed range.
REQ-020 SHALL have latency of exactly 2 cycles from input handshake to out_valid when out_ready is held high.
REQ-021 SHALL sustain one transfer per cycle when out_ready is held high.
REQ-022 SHALL advance stage 2 when !out_valid || out_ready, and stage 1 when its slot is empty or moving into stage 2.
REQ-023 SHALL drive in_ready = !s1_valid || stage-2 advance, combinationally, with no dependence on in_valid.
REQ-024 SHALL hold out_y, out_sat, out_valid stable while out_valid && !out_ready.
REQ-025 SHALL, when out_ready is low, hold both pipeline stages full and deassert in_ready; no beat may be lost or duplicated.
REQ-026 SHALL, on simultaneous output handshake and input handshake with both stages full, shift all stages in the same cycle.
REQ-027 SHALL produce out_y=0, out_sat=0 for in_g=0 or in_a=0.

Reset
REQ-028 SHALL, while rst_n=0, asynchronously clear s1_valid, out_valid, out_sat to 0 and out_y and the product register to 0.
REQ-029 SHALL discard in-flight beats on reset mid-operation; the first output after reset release corresponds to the first post-reset input handshake.
REQ-030 SHALL drive in_ready=1 in the first cycle after reset release.

Configuration
REQ-031 SHALL, with macro GAIN_SCALE_ROUND_EN defined, add 2^(SHIFT-1) to the product before the shift (round half up); without it, the shift truncates toward minus infinity; for SHIFT=0 no rounding term is added in either case.

Verification
REQ-032 SHALL cover: in_a=-10, in_g=120, out_ready=1 -> out_y=-5, out_sat=0, out_valid exactly 2 cycles after handshake.
REQ-033 SHALL cover: in_a=-1, in_g=128 -> out_y=-1 without GAIN_SCALE_ROUND_EN, out_y=0 with it.
REQ-034 SHALL cover: in_a=32767, in_g=65535 -> out_y=32767, out_sat=1; in_a=-32768, in_g=65535 -> out_y=-32768, out_sat=1.
REQ-035 SHALL cover: in_valid held high with ramp in_a=1..6, in_g=256, out_ready low for cycles 3-5 -> in_ready low while both stages full, outputs 1..6 in order with none lost or repeated.
REQ-036 SHALL cover: rst_n pulsed low with both stages full -> out_valid=0 immediately, in_ready=1 after release, no stale beat emitted.

Source files
------------

// File: rtl/gain_scale_sat_if.sv
// Valid/ready bundle for gain_scale_sat: sample+gain in, saturated result out.
// slave is the block side, master is the driver/consumer side.
interface gain_scale_sat_if #(
    parameter int A_W   = 16,
    parameter int G_W   = 16,
    parameter int OUT_W = 16
);
    logic                    in_valid;
    logic                    in_ready;
    logic signed [A_W-1:0]   in_a;
    logic        [G_W-1:0]   in_g;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [OUT_W-1:0] out_y;
    logic                    out_sat;

    modport slave (
        input  in_valid, in_a, in_g, out_ready,
        output in_ready, out_valid, out_y, out_sat
    );

    modport master (
        output in_valid, in_a, in_g, out_ready,
        input  in_ready, out_valid, out_y, out_sat
    );
endinterface

// File: rtl/gain_scale_sat.sv
// Two-stage signed*unsigned gain, arithmetic shift and saturation.
// Define GAIN_SCALE_ROUND_EN to round half up before the shift.
module gain_scale_sat #(
    parameter int A_W   = 16,
    parameter int G_W   = 16,
    parameter int SHIFT = 8,
    parameter int OUT_W = 16
) (
    input logic             clk,
    input logic             rst_n,
    gain_scale_sat_if.slave io
);
    localparam int P_W = A_W + G_W + 1;
    localparam int S_W = P_W + 1;

    localparam logic signed [S_W-1:0] MAX_V =
        {{(S_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [S_W-1:0] MIN_V =
        {{(S_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

`ifdef GAIN_SCALE_ROUND_EN
    localparam int RND_SH = (SHIFT > 0) ? SHIFT - 1 : 0;
    localparam logic signed [S_W-1:0] RND_V =
        (SHIFT > 0) ? (S_W'(1) <<< RND_SH) : '0;
`else
    localparam logic signed [S_W-1:0] RND_V = '0;
`endif

    logic signed [P_W-1:0]   prod_d;
    logic signed [P_W-1:0]   prod_q;
    logic                    s1_valid_q;
    logic                    out_valid_q;
    logic                    out_sat_d;
    logic                    out_sat_q;
    logic signed [OUT_W-1:0] out_y_d;
    logic signed [OUT_W-1:0] out_y_q;
    logic                    s1_adv;
    logic                    s2_adv;
    logic signed [S_W-1:0]   ext_s;
    logic signed [S_W-1:0]   rnd_s;
    logic signed [S_W-1:0]   shf_s;

    // Gain gets a zero MSB so it is never read as negative.
    assign prod_d = P_W'($signed(io.in_a))
                  * P_W'($signed({1'b0, io.in_g}));

    assign s2_adv = !out_valid_q || io.out_ready;
    assign s1_adv = !s1_valid_q || s2_adv;

    assign io.in_ready  = s1_adv;
    assign io.out_valid = out_valid_q;
    assign io.out_y     = out_y_q;
    assign io.out_sat   = out_sat_q;

    assign ext_s = S_W'(prod_q);
    assign rnd_s = ext_s + RND_V;
    assign shf_s = rnd_s >>> SHIFT;

    always_comb begin
        out_sat_d = 1'b0;
        out_y_d   = OUT_W'(shf_s);
        if (shf_s > MAX_V) begin
            out_sat_d = 1'b1;
            out_y_d   = OUT_W'(MAX_V);
        end else if (shf_s < MIN_V) begin
            out_sat_d = 1'b1;
            out_y_d   = OUT_W'(MIN_V);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            prod_q     <= '0;
        end else if (s1_adv) begin
            s1_valid_q <= io.in_valid;
            if (io.in_valid) begin
                prod_q <= prod_d;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_sat_q   <= 1'b0;
            out_y_q     <= '0;
        end else if (s2_adv) begin
            out_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                out_y_q   <= out_y_d;
                out_sat_q <= out_sat_d;
            end
        end
    end
endmodule

// File: tb/tb_gain_scale_sat.sv
// Directed bench for gain_scale_sat with default 16/16/8/16 parameters.
// Expected values are hand-computed; rounding vectors follow GAIN_SCALE_ROUND_EN.
module tb_gain_scale_sat;
    logic clk;
    logic rst_n;
    int   checks;
    int   fails;

    gain_scale_sat_if #(.A_W(16), .G_W(16), .OUT_W(16)) io ();

    gain_scale_sat #(
        .A_W(16), .G_W(16), .SHIFT(8), .OUT_W(16)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (io.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One beat with out_ready high: out_valid must appear exactly 2 edges later.
    task automatic send(input string tag,
                        input logic signed [15:0] a,
                        input logic [15:0] g,
                        input logic signed [15:0] ey,
                        input logic esat);
        io.out_ready = 1'b1;
        io.in_valid  = 1'b1;
        io.in_a      = a;
        io.in_g      = g;
        #1;
        chk({tag, "_in_ready"}, 32'(io.in_ready), 1);
        tick();
        io.in_valid = 1'b0;
        chk({tag, "_lat1_valid"}, 32'(io.out_valid), 0);
        tick();
        chk({tag, "_valid"}, 32'(io.out_valid), 1);
        chk({tag, "_y"}, io.out_y, ey);
        chk({tag, "_sat"}, 32'(io.out_sat), 32'(esat));
        tick();
        chk({tag, "_drain"}, 32'(io.out_valid), 0);
    endtask

    initial begin
        int sent;
        int got;
        int cyc;
        logic stall_prev;
        logic signed [15:0] held;
        logic signed [15:0] exp_round;

        checks       = 0;
        fails        = 0;
        rst_n        = 1'b0;
        io.in_valid  = 1'b0;
        io.in_a      = '0;
        io.in_g      = '0;
        io.out_ready = 1'b1;

        #2;
        chk("rst_out_valid", 32'(io.out_valid), 0);
        chk("rst_out_sat", 32'(io.out_sat), 0);
        chk("rst_out_y", io.out_y, 0);
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        chk("post_rst_in_ready", 32'(io.in_ready), 1);
        tick();

        send("neg_small", -16'sd10, 16'd120, -16'sd5, 1'b0);
`ifdef GAIN_SCALE_ROUND_EN
        exp_round = 16'sd0;
`else
        exp_round = -16'sd1;
`endif
        send("round_m1", -16'sd1, 16'd128, exp_round, 1'b0);
        send("sat_pos", 16'sd32767, 16'd65535, 16'sd32767, 1'b1);
        send("sat_neg", -16'sd32768, 16'd65535, -16'sd32768, 1'b1);
        send("zero_g", 16'sd12345, 16'd0, 16'sd0, 1'b0);
        send("zero_a", 16'sd0, 16'd65535, 16'sd0, 1'b0);
`ifdef GAIN_SCALE_ROUND_EN
        exp_round = 16'sd1172;
`else
        exp_round = 16'sd1171;
`endif
        send("pos_mid", 16'sd1000, 16'd300, exp_round, 1'b0);
        send("neg_sat_mid", -16'sd20000, 16'd1024, -16'sd32768, 1'b1);

        // Ramp 1..6 at unity gain with out_ready low in cycles 3-5.
        sent       = 0;
        got        = 0;
        cyc        = 0;
        stall_prev = 1'b0;
        held       = '0;
        while (got < 6 && cyc < 40) begin
            cyc++;
            io.out_ready = !(cyc >= 3 && cyc <= 5);
            io.in_valid  = (sent < 6);
            io.in_a      = 16'(sent + 1);
            io.in_g      = 16'd256;
            #1;
            chk("ramp_in_ready", 32'(io.in_ready),
                32'(!((sent - got) == 2 && !io.out_ready)));
            if (stall_prev) begin
                chk("ramp_hold_valid", 32'(io.out_valid), 1);
                chk("ramp_hold_y", io.out_y, held);
            end
            if (io.out_valid && io.out_ready) begin
                chk("ramp_y", io.out_y, got + 1);
                got++;
            end
            stall_prev = io.out_valid && !io.out_ready;
            held       = io.out_y;
            if (io.in_valid && io.in_ready) sent++;
            tick();
        end
        io.in_valid = 1'b0;
        chk("ramp_count", got, 6);
        chk("ramp_no_dup", 32'(io.out_valid), 0);
        tick();
        chk("ramp_no_dup2", 32'(io.out_valid), 0);

        // Fill both stages under backpressure, then reset mid-flight.
        io.out_ready = 1'b0;
        io.in_g      = 16'd256;
        io.in_valid  = 1'b1;
        io.in_a      = 16'sd7;
        tick();
        io.in_a = 16'sd8;
        tick();
        io.in_valid = 1'b0;
        chk("full_out_valid", 32'(io.out_valid), 1);
        chk("full_in_ready", 32'(io.in_ready), 0);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(io.out_valid), 0);
        chk("midrst_out_y", io.out_y, 0);
        tick();
        rst_n = 1'b1;
        #1;
        chk("midrst_in_ready", 32'(io.in_ready), 1);
        io.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("no_stale", 32'(io.out_valid), 0);
        end
        send("after_rst", 16'sd9, 16'd256, 16'sd9, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end
endmodule
